// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 keyboard transmitter types, constants and parity helper
// Purpose: FSM state encoding, frame length, scan-code constants and the odd-parity function
//          used by ps2_kbd_tx.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Parity bit that makes the total number of ones over data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// rtl/ps2_tx_fifo.sv - synchronous scan-code FIFO for the PS/2 keyboard transmitter
// Purpose: buffers 8-bit scan codes between the byte source and the frame serialiser.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset (empties the FIFO)
//   push_valid       byte offered; accepted when push_ready is high
//   push_data [7:0]  byte to store
//   push_ready       FIFO not full
//   pop              remove the oldest entry (ignored when empty)
//   rdata [7:0]      oldest entry, valid while empty is low
//   full, empty      occupancy flags
module ps2_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = ~full;
  assign do_push    = push_valid & ~full;
  // Pop is qualified by the registered count, so a byte written this cycle
  // cannot be popped until the next one.
  assign do_pop     = pop & ~empty;
  assign rdata      = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - device-side PS/2 keyboard transmitter
// Purpose: buffers scan-code bytes and serialises each as an 11-bit PS/2 frame
//          (start, 8 data LSB first, odd parity, stop), driving ps2_clk and ps2_data.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   in_valid        scan-code byte offered
//   in_data [7:0]   scan-code byte
//   in_ready        FIFO not full; byte taken when in_valid & in_ready
//   ps2_clk         PS/2 clock, registered, idle high
//   ps2_data        PS/2 data, registered, idle high
//   busy            frame in progress or bytes buffered
//   frame_done      one-cycle pulse at the end of the stop bit
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_state_t        state, state_nxt;
  logic [DIV_W-1:0]  div, div_nxt;
  logic [3:0]        bit_cnt, bit_nxt;
  logic [GAP_W-1:0]  gap, gap_nxt;
  logic [10:0]       shreg, shreg_nxt;
  logic              clk_nxt, data_nxt, done_nxt;
  logic              load;
  logic              pop;
  logic [7:0]        rdata;
  logic              full;
  logic              empty;

  ps2_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (in_valid),
    .push_data  (in_data),
    .push_ready (in_ready),
    .pop        (pop),
    .rdata      (rdata),
    .full       (full),
    .empty      (empty)
  );

  assign busy = (state != IDLE) | ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      gap        <= '0;
      shreg      <= '1;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div        <= div_nxt;
      bit_cnt    <= bit_nxt;
      gap        <= gap_nxt;
      shreg      <= shreg_nxt;
      ps2_clk    <= clk_nxt;
      ps2_data   <= data_nxt;
      frame_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    bit_nxt   = bit_cnt;
    gap_nxt   = gap;
    shreg_nxt = shreg;
    clk_nxt   = ps2_clk;
    data_nxt  = ps2_data;
    done_nxt  = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        clk_nxt  = 1'b1;
        data_nxt = 1'b1;
        load     = ~empty;
      end
      BIT_HI: begin
        if (div == DIV_LAST) begin
          clk_nxt   = 1'b0;
          div_nxt   = '0;
          state_nxt = BIT_LO;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      BIT_LO: begin
        if (div == DIV_LAST) begin
          clk_nxt = 1'b1;
          div_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            data_nxt  = 1'b1;
            done_nxt  = 1'b1;
            gap_nxt   = '0;
            state_nxt = GAP;
          end else begin
            // Data only moves on the ps2_clk rising edge; shreg[1] is the bit after the current one.
            data_nxt  = shreg[1];
            shreg_nxt = {1'b1, shreg[10:1]};
            bit_nxt   = bit_cnt + 4'd1;
            state_nxt = BIT_HI;
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      GAP: begin
        clk_nxt  = 1'b1;
        data_nxt = 1'b1;
        if (gap == GAP_LAST) begin
          state_nxt = IDLE;
          // Start the next queued byte straight out of the gap so back-to-back
          // frames are separated by exactly GAP_CYCLES idle cycles.
          load      = ~empty;
        end else begin
          gap_nxt = gap + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      pop       = 1'b1;
      shreg_nxt = {1'b1, odd_parity(rdata), rdata, 1'b0};
      data_nxt  = 1'b0;
      clk_nxt   = 1'b1;
      bit_nxt   = '0;
      div_nxt   = '0;
      state_nxt = BIT_HI;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb/tb_ps2_kbd_tx.sv - self-checking bench for ps2_kbd_tx with host-side receiver model
module tb_ps2_kbd_tx;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       frame_done;

  ps2_kbd_tx #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (8),
    .GAP_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int cyc = 0, edge_cnt = 0, done_cnt = 0, nframes = 0, gap_seen = 0;
  int n_push = 0, n_start = 0, rx_idx = 0;
  int start_cyc = 0, last_done_cyc = 0, busy_fall_cyc = 0;
  int quiet_viol = 0, busy_viol = 0, full_seen = 0;
  bit rx_active = 0, held = 0, occ_chk = 0, quiet_chk = 0, busy_chk = 0;
  logic [10:0] rx_bits = '0, last_bits = '0;
  logic prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic decode();
    logic [7:0] e;
    nframes++;
    last_bits = rx_bits;
    chk("start_bit", {31'd0, rx_bits[0]}, 32'd0);
    chk("stop_bit", {31'd0, rx_bits[10]}, 32'd1);
    chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rx_data", {24'd0, rx_bits[8:1]}, {24'd0, e});
      chk("parity", {31'd0, rx_bits[9]}, {31'd0, ~^e});
    end
  endtask

  // Host-side receiver and line monitor, sampling mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      rx_idx = 0; rx_active = 0; n_start = 0; held = 0;
    end else begin
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      if (!busy) held = 0;
      if (prev_data && !ps2_data && ps2_clk && !rx_active) begin
        rx_active = 1; rx_idx = 0; start_cyc = cyc; n_start++;
        if (held) begin
          gap_seen++;
          chk("gap_len", cyc - last_done_cyc, 32'd16);
        end
      end
      if (prev_clk && !ps2_clk) begin
        edge_cnt++;
        if (rx_active && rx_idx < 11) begin
          rx_bits[rx_idx] = ps2_data;
          rx_idx++;
          if (rx_idx == 11) decode();
        end
      end
      if (frame_done) begin
        done_cnt++; last_done_cyc = cyc; held = 1;
        chk("frame_len", cyc - start_cyc, 32'd88);
        rx_active = 0;
      end
      if (occ_chk) begin
        if (!in_ready) full_seen++;
        chk("in_ready_occ", {31'd0, in_ready}, {31'd0, (n_push - n_start) != 8});
      end
      if (quiet_chk && (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || frame_done !== 1'b0 || in_ready !== 1'b1))
        quiet_viol++;
      if (busy_chk && exp_q.size() != 0 && !busy) busy_viol++;
    end
    prev_clk = ps2_clk; prev_data = ps2_data; prev_busy = busy;
  end

  // Called just after a posedge; leaves in_valid low just after the accepting edge.
  task automatic push(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 5000) break;
    end
    chk("push_timeout", {31'd0, t > 5000}, 32'd0);
    @(posedge clk);
    exp_q.push_back(b);
    n_push++;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int t = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) break;
      t++;
      if (t > max_cyc) break;
    end
    chk("idle_timeout", {31'd0, t > max_cyc}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, d0, e0, g0;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    chk("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle for 1000 cycles: lines quiet.
    quiet_chk = 1;
    repeat (1000) @(negedge clk);
    quiet_chk = 0;
    chk("quiet_viol", quiet_viol, 32'd0);
    @(posedge clk);
    #1;

    // Single 0x1C frame.
    n0 = nframes; d0 = done_cnt;
    push(8'h1C);
    wait_idle(3000);
    chk("t1_frames", nframes - n0, 32'd1);
    chk("t1_bits", {21'd0, last_bits}, {21'd0, 11'h438});
    chk("t1_done", done_cnt - d0, 32'd1);

    // 0x00 then 0xFF back to back.
    n0 = nframes; g0 = gap_seen;
    push(8'h00);
    push(8'hFF);
    wait_idle(3000);
    chk("t2_frames", nframes - n0, 32'd2);
    chk("t2_gaps", gap_seen - g0, 32'd1);

    // Make / break burst with busy held throughout.
    n0 = nframes; busy_chk = 1;
    push(8'h1C);
    push(PS2_BREAK);
    push(8'h1C);
    wait_idle(3000);
    busy_chk = 0;
    chk("t3_frames", nframes - n0, 32'd3);
    chk("t3_busy_viol", busy_viol, 32'd0);
    chk("t3_busy_fall", busy_fall_cyc - last_done_cyc, 32'd16);

    // 12 bytes held valid: FIFO fills, in_ready tracks occupancy.
    n0 = nframes; occ_chk = 1;
    push(PS2_EXT);
    for (int i = 1; i < 12; i++) push(8'(8'h11 + i * 7));
    wait_idle(5000);
    occ_chk = 0;
    chk("t4_frames", nframes - n0, 32'd12);
    chk("t4_full_seen", {31'd0, full_seen > 0}, 32'd1);

    // Reset after the 5th falling edge of a frame.
    push(8'h1C);
    begin
      int t = 0;
      forever begin
        @(negedge clk);
        #1;
        if (rx_idx >= 5) break;
        t++;
        if (t > 500) break;
      end
      chk("t5_edge_wait", {31'd0, t > 500}, 32'd0);
    end
    #2 reset = 1'b1;
    #1;
    chk("t5_ps2_clk", {31'd0, ps2_clk}, 32'd1);
    chk("t5_ps2_data", {31'd0, ps2_data}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    n_push = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    e0 = edge_cnt;
    repeat (100) @(negedge clk);
    chk("t5_no_edges", edge_cnt - e0, 32'd0);
    @(posedge clk);
    #1;
    n0 = nframes;
    push(8'h29);
    wait_idle(3000);
    chk("t5_frames", nframes - n0, 32'd1);
    chk("done_vs_frames", done_cnt, nframes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
